display_data_sequencer: RTL and testbench

Periodic sampling controller that sits between the ADC/I²C temperature front ends and the 8-digit seven-segment display mux. Once per refresh period it:
- requests one ADC conversion and one temperature read over req/ack handshakes;
- converts the battery voltage to a percentage with a multi-cycle restoring divider, so no combinational divide remains in the display path;
- double-dabbles both values to BCD;
- publishes them atomically as stable, glitch-free digits.

---
 rtl/display_pkg.sv | 35 +++
 rtl/restoring_div.sv | 74 +++++++
 rtl/display_data_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_display_data_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the display data sequencer and its divider.
package display_pkg;

  localparam int NUM_W = 27;
  localparam int DEN_W = 20;
  localparam int PCT_W = 7;

  localparam logic [23:0] ADC_MIN_DEF = 24'd3000000;
  localparam logic [23:0] ADC_MAX_DEF = 24'd3900000;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADC_WAIT,
    ST_TEMP_WAIT,
    ST_CALC,
    ST_DIV,
    ST_BCD,
    ST_PUBLISH
  } state_t;

  // One double-dabble iteration on {hundreds, tens, ones, binary[7:0]}.
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] t;
    bcd_digit_t  d;
    t = v;
    for (int unsigned i = 0; i < 3; i++) begin
      d = t[8 + 4*i +: 4];
      if (d >= 4'd5) t[8 + 4*i +: 4] = d + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/restoring_div.sv
// Multi-cycle restoring divider: one quotient bit per clock, NUM_W steps after start.
module restoring_div #(
  parameter int NUM_W = 27,
  parameter int DEN_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] quo_q, quo_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [DEN_W:0]   shifted;
  logic [DEN_W+1:0] trial;

  always_comb begin
    shifted = {rem_q, quo_q[NUM_W-1]};
    trial   = {1'b0, shifted} - {2'b00, den_q};
    quo_d   = quo_q;
    rem_d   = rem_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start) begin
      quo_d  = num;
      rem_d  = '0;
      den_d  = den;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Partial remainder stays below den, so DEN_W bits always suffice.
      if (!trial[DEN_W+1]) begin
        rem_d = trial[DEN_W-1:0];
        quo_d = {quo_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_d = shifted[DEN_W-1:0];
        quo_d = {quo_q[NUM_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(NUM_W - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // High while the final quotient bit is being produced; quotient is final after this edge.
  assign done     = busy_q && (cnt_q == CNT_W'(NUM_W - 1));
  assign quotient = quo_q;

endmodule

// File: rtl/display_data_sequencer.sv
// Periodic ADC/temperature sampler: handshake capture, divide to percent, BCD, atomic publish.
module display_data_sequencer
  import display_pkg::*;
#(
  parameter int          REFRESH_CYCLES = 10_000_000,
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter logic [23:0] ADC_MIN        = ADC_MIN_DEF,
  parameter logic [23:0] ADC_MAX        = ADC_MAX_DEF
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  output logic        adc_req,
  input  logic        adc_ack,
  input  logic [23:0] adc_value,
  output logic        temp_req,
  input  logic        temp_ack,
  input  logic [7:0]  temp_data,
  output logic [11:0] pct_bcd,
  output logic [7:0]  temp_bcd,
  output logic        data_valid,
  output logic [1:0]  stale
);

  localparam int REF_W = $clog2(REFRESH_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state_q, state_d;
  logic [REF_W-1:0] ref_q, ref_d;
  logic             pending_q, pending_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [23:0]      adc_q, adc_d;
  logic [7:0]       temp_q, temp_d;
  logic [1:0]       flags_q, flags_d;
  logic             clamp_lo_q, clamp_lo_d;
  logic             clamp_hi_q, clamp_hi_d;
  logic [2:0]       bcd_cnt_q, bcd_cnt_d;
  logic [19:0]      pct_sr_q, pct_sr_d;
  logic [15:0]      temp_sr_q, temp_sr_d;
  logic             adc_req_q, adc_req_d;
  logic             temp_req_q, temp_req_d;
  logic [11:0]      pct_bcd_q, pct_bcd_d;
  logic [7:0]       temp_bcd_q, temp_bcd_d;
  logic             data_valid_q, data_valid_d;
  logic [1:0]       stale_q, stale_d;

  logic             ref_wrap, tmo_last;
  logic [7:0]       pct_bin, temp_sat;
  logic             div_start, div_done;
  logic [NUM_W-1:0] div_num, div_quo;
  logic [DEN_W-1:0] div_den;

  assign div_start = (state_q == ST_CALC);
  assign div_num   = NUM_W'(adc_q - ADC_MIN) * NUM_W'(100);
  assign div_den   = DEN_W'(ADC_MAX - ADC_MIN);

  restoring_div #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W)
  ) u_div (
    .clk      (CLK100MHZ),
    .rst_n    (CPU_RESETN),
    .start    (div_start),
    .num      (div_num),
    .den      (div_den),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    tmo_d        = tmo_q;
    adc_d        = adc_q;
    temp_d       = temp_q;
    flags_d      = flags_q;
    clamp_lo_d   = clamp_lo_q;
    clamp_hi_d   = clamp_hi_q;
    bcd_cnt_d    = bcd_cnt_q;
    pct_sr_d     = pct_sr_q;
    temp_sr_d    = temp_sr_q;
    adc_req_d    = adc_req_q;
    temp_req_d   = temp_req_q;
    pct_bcd_d    = pct_bcd_q;
    temp_bcd_d   = temp_bcd_q;
    data_valid_d = 1'b0;
    stale_d      = stale_q;

    ref_wrap = (ref_q == REF_W'(REFRESH_CYCLES - 1));
    ref_d    = ref_wrap ? '0 : ref_q + 1'b1;
    tmo_last = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Out-of-range quotient bits only occur when clamped; treat them as full scale.
    if (clamp_hi_q || (|div_quo[NUM_W-1:PCT_W])) pct_bin = 8'd100;
    else if (clamp_lo_q)                         pct_bin = 8'd0;
    else                                         pct_bin = {1'b0, div_quo[PCT_W-1:0]};
    temp_sat = (temp_q > 8'd99) ? 8'd99 : temp_q;

    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          pending_d = 1'b0;
          adc_req_d = 1'b1;
          tmo_d     = '0;
          state_d   = ST_ADC_WAIT;
        end
      end
      ST_ADC_WAIT: begin
        if (adc_ack || tmo_last) begin
          if (adc_ack) adc_d = adc_value;
          flags_d[0] = !adc_ack;
          adc_req_d  = 1'b0;
          temp_req_d = 1'b1;
          tmo_d      = '0;
          state_d    = ST_TEMP_WAIT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_TEMP_WAIT: begin
        if (temp_ack || tmo_last) begin
          if (temp_ack) temp_d = temp_data;
          flags_d[1] = !temp_ack;
          temp_req_d = 1'b0;
          state_d    = ST_CALC;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_CALC: begin
        clamp_lo_d = (adc_q <= ADC_MIN);
        clamp_hi_d = (adc_q >= ADC_MAX);
        state_d    = ST_DIV;
      end
      ST_DIV: begin
        if (div_done) begin
          bcd_cnt_d = '0;
          state_d   = ST_BCD;
        end
      end
      ST_BCD: begin
        // First step loads the binary operands and shifts in the same cycle.
        pct_sr_d  = dabble_step((bcd_cnt_q == '0) ? {12'h000, pct_bin} : pct_sr_q);
        temp_sr_d = 16'(dabble_step({4'h0, (bcd_cnt_q == '0) ? {8'h00, temp_sat} : temp_sr_q}));
        bcd_cnt_d = bcd_cnt_q + 1'b1;
        if (bcd_cnt_q == 3'd7) state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        pct_bcd_d    = pct_sr_q[19:8];
        temp_bcd_d   = temp_sr_q[15:8];
        stale_d      = flags_q;
        data_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (ref_wrap) pending_d = 1'b1;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q      <= ST_IDLE;
      ref_q        <= '0;
      pending_q    <= 1'b1;
      tmo_q        <= '0;
      adc_q        <= '0;
      temp_q       <= '0;
      flags_q      <= '0;
      clamp_lo_q   <= 1'b0;
      clamp_hi_q   <= 1'b0;
      bcd_cnt_q    <= '0;
      pct_sr_q     <= '0;
      temp_sr_q    <= '0;
      adc_req_q    <= 1'b0;
      temp_req_q   <= 1'b0;
      pct_bcd_q    <= '0;
      temp_bcd_q   <= '0;
      data_valid_q <= 1'b0;
      stale_q      <= '0;
    end else begin
      state_q      <= state_d;
      ref_q        <= ref_d;
      pending_q    <= pending_d;
      tmo_q        <= tmo_d;
      adc_q        <= adc_d;
      temp_q       <= temp_d;
      flags_q      <= flags_d;
      clamp_lo_q   <= clamp_lo_d;
      clamp_hi_q   <= clamp_hi_d;
      bcd_cnt_q    <= bcd_cnt_d;
      pct_sr_q     <= pct_sr_d;
      temp_sr_q    <= temp_sr_d;
      adc_req_q    <= adc_req_d;
      temp_req_q   <= temp_req_d;
      pct_bcd_q    <= pct_bcd_d;
      temp_bcd_q   <= temp_bcd_d;
      data_valid_q <= data_valid_d;
      stale_q      <= stale_d;
    end
  end

  assign adc_req    = adc_req_q;
  assign temp_req   = temp_req_q;
  assign pct_bcd    = pct_bcd_q;
  assign temp_bcd   = temp_bcd_q;
  assign data_valid = data_valid_q;
  assign stale      = stale_q;

endmodule

// File: tb/tb_display_data_sequencer.sv
// Directed bench for display_data_sequencer with short refresh/timeout periods.
module tb_display_data_sequencer;

  localparam int REFRESH = 200;
  localparam int TIMEOUT = 40;

  logic        clk;
  logic        rst_n;
  logic        adc_req, adc_ack;
  logic [23:0] adc_value;
  logic        temp_req, temp_ack;
  logic [7:0]  temp_data;
  logic [11:0] pct_bcd;
  logic [7:0]  temp_bcd;
  logic        data_valid;
  logic [1:0]  stale;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  display_data_sequencer #(
    .REFRESH_CYCLES (REFRESH),
    .TIMEOUT_CYCLES (TIMEOUT),
    .ADC_MIN        (24'd3000000),
    .ADC_MAX        (24'd3900000)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .adc_req    (adc_req),
    .adc_ack    (adc_ack),
    .adc_value  (adc_value),
    .temp_req   (temp_req),
    .temp_ack   (temp_ack),
    .temp_data  (temp_data),
    .pct_bcd    (pct_bcd),
    .temp_bcd   (temp_bcd),
    .data_valid (data_valid),
    .stale      (stale)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_adc_req"},  32'(adc_req),    32'd0);
    chk({tag, "_temp_req"}, 32'(temp_req),   32'd0);
    chk({tag, "_pct"},      32'(pct_bcd),    32'h000);
    chk({tag, "_temp"},     32'(temp_bcd),   32'h00);
    chk({tag, "_dv"},       32'(data_valid), 32'd0);
    chk({tag, "_stale"},    32'(stale),      32'd0);
  endtask

  task automatic wait_adc_req();
    int n = 0;
    while (!adc_req && n < 400) begin @(negedge clk); n++; end
    chk("adc_req_wait", 32'(adc_req), 32'd1);
  endtask

  task automatic ack_adc(input logic [23:0] v);
    wait_adc_req();
    adc_value = v;
    adc_ack   = 1'b1;
    @(negedge clk);
    adc_ack   = 1'b0;
    adc_value = 24'hABCDEF;
  endtask

  task automatic ack_temp(input logic [7:0] v, output int ack_cyc);
    int n = 0;
    while (!temp_req && n < 400) begin @(negedge clk); n++; end
    chk("temp_req_wait", 32'(temp_req), 32'd1);
    temp_data = v;
    temp_ack  = 1'b1;
    ack_cyc   = cyc;
    @(negedge clk);
    temp_ack  = 1'b0;
    temp_data = 8'hEE;
  endtask

  // Runs one round; when do_adc is 0 the ADC is left unanswered to force a timeout.
  task automatic run_round(input bit do_adc, input logic [23:0] av, input logic [7:0] tv,
                           input logic [11:0] ep, input logic [7:0] et, input logic [1:0] es);
    int ack_cyc, hi, n;
    if (do_adc) begin
      ack_adc(av);
    end else begin
      wait_adc_req();
      hi = 0;
      while (adc_req && hi < 200) begin @(negedge clk); hi++; end
      chk("adc_timeout_len", 32'(hi), 32'(TIMEOUT));
      chk("temp_req_after_timeout", 32'(temp_req), 32'd1);
    end
    ack_temp(tv, ack_cyc);
    n = 0;
    while (!data_valid && n < 100) begin @(negedge clk); n++; end
    chk("data_valid_seen", 32'(data_valid), 32'd1);
    chk("publish_latency", 32'(cyc - ack_cyc), 32'd38);
    chk("pct_bcd",  32'(pct_bcd),  32'(ep));
    chk("temp_bcd", 32'(temp_bcd), 32'(et));
    chk("stale",    32'(stale),    32'(es));
    @(negedge clk);
    chk("dv_one_cycle", 32'(data_valid), 32'd0);
    chk("pct_hold",     32'(pct_bcd),    32'(ep));
  endtask

  initial begin
    int ack_cyc;
    bit dv_seen;
    rst_n     = 1'b0;
    adc_ack   = 1'b0;
    temp_ack  = 1'b0;
    adc_value = '0;
    temp_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    rst_n = 1'b1;
    @(negedge clk);
    chk("first_round_start", 32'(adc_req), 32'd1);
    run_round(1'b1, 24'd3450000, 8'd25,  12'h050, 8'h25, 2'b00);
    run_round(1'b1, 24'd2000000, 8'd30,  12'h000, 8'h30, 2'b00);
    run_round(1'b1, 24'd3900000, 8'd31,  12'h100, 8'h31, 2'b00);
    run_round(1'b1, 24'd4000000, 8'd32,  12'h100, 8'h32, 2'b00);
    run_round(1'b1, 24'd3899999, 8'd150, 12'h099, 8'h99, 2'b00);
    run_round(1'b1, 24'd3000001, 8'd0,   12'h000, 8'h00, 2'b00);
    run_round(1'b1, 24'd3450000, 8'd42,  12'h050, 8'h42, 2'b00);

    // Acks while idle must not be captured; the timeout round below reuses the old ADC code.
    adc_value = 24'd3900000;
    adc_ack   = 1'b1;
    temp_data = 8'd99;
    temp_ack  = 1'b1;
    @(negedge clk);
    chk("idle_adc_req", 32'(adc_req), 32'd0);
    chk("idle_temp_req", 32'(temp_req), 32'd0);
    adc_ack  = 1'b0;
    temp_ack = 1'b0;

    run_round(1'b0, 24'd0,       8'd77, 12'h050, 8'h77, 2'b01);
    run_round(1'b1, 24'd3123456, 8'd5,  12'h013, 8'h05, 2'b00);

    // Reset while the divider is busy.
    ack_adc(24'd3600000);
    ack_temp(8'd60, ack_cyc);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    dv_seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (data_valid) dv_seen = 1'b1;
    end
    chk("no_dv_in_reset", 32'(dv_seen), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_round", 32'(adc_req), 32'd1);
    run_round(1'b1, 24'd3675000, 8'd88, 12'h075, 8'h88, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
